// File: rtl/pipeline_stall_ctrl_pkg.sv
// rtl/pipeline_stall_ctrl_pkg.sv - shared types and widths for the pipeline stall controller
package pipeline_stall_ctrl_pkg;

    localparam int MISS_CNT_W  = 8;
    localparam int STALL_CNT_W = 16;
    localparam int REG_ADDR_W  = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DMISS = 2'd1,
        IMISS = 2'd2
    } state_t;

    typedef struct packed {
        logic pc_we;
        logic if_id_we;
        logic id_ex_we;
        logic ex_mem_we;
        logic if_id_flush;
        logic id_ex_bubble;
        logic mem_wb_bubble;
    } ctrl_t;

    // Every stage advances, nothing is squashed.
    localparam ctrl_t CTRL_RUN   = ctrl_t'{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    // Nothing advances and every pipeline register is loaded with a NOP.
    localparam ctrl_t CTRL_RESET = ctrl_t'{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    function automatic logic is_miss_state(input state_t s);
        return (s == DMISS) || (s == IMISS);
    endfunction

endpackage

// File: rtl/pipeline_stall_ctrl_if.sv
// rtl/pipeline_stall_ctrl_if.sv - hazard inputs and stage controls between datapath and stall controller
interface pipeline_stall_ctrl_if;

    logic                                          instruction_hit;
    logic                                          data_hit;
    logic                                          mem_access;
    logic                                          id_ex_memread;
    logic [pipeline_stall_ctrl_pkg::REG_ADDR_W-1:0] id_ex_rt;
    logic [pipeline_stall_ctrl_pkg::REG_ADDR_W-1:0] if_id_rs;
    logic [pipeline_stall_ctrl_pkg::REG_ADDR_W-1:0] if_id_rt;
    logic                                          branch_taken;

    logic                                          pc_we;
    logic                                          if_id_we;
    logic                                          id_ex_we;
    logic                                          ex_mem_we;
    logic                                          if_id_flush;
    logic                                          id_ex_bubble;
    logic                                          mem_wb_bubble;
    logic                                          miss_timeout;

    // Datapath side: reports hazards, obeys stage controls.
    modport master (
        output instruction_hit, data_hit, mem_access, id_ex_memread,
               id_ex_rt, if_id_rs, if_id_rt, branch_taken,
        input  pc_we, if_id_we, id_ex_we, ex_mem_we,
               if_id_flush, id_ex_bubble, mem_wb_bubble, miss_timeout
    );

    // Controller side.
    modport slave (
        input  instruction_hit, data_hit, mem_access, id_ex_memread,
               id_ex_rt, if_id_rs, if_id_rt, branch_taken,
        output pc_we, if_id_we, id_ex_we, ex_mem_we,
               if_id_flush, id_ex_bubble, mem_wb_bubble, miss_timeout
    );

endinterface

// File: rtl/pipeline_stall_ctrl_hazard_detect.sv
// rtl/pipeline_stall_ctrl_hazard_detect.sv - load-use hazard comparator
module hazard_detect
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic                  id_ex_memread,
    input  logic [REG_ADDR_W-1:0] id_ex_rt,
    input  logic [REG_ADDR_W-1:0] if_id_rs,
    input  logic [REG_ADDR_W-1:0] if_id_rt,
    output logic                  load_use
);

    // Register 0 is hardwired, so a load targeting it can never create a dependency.
    assign load_use = id_ex_memread && (id_ex_rt != '0) &&
                      ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// rtl/pipeline_stall_ctrl.sv - pipeline stall/flush controller; STALL_CNT_EN adds the stall_cnt port
module pipeline_stall_ctrl
    import pipeline_stall_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    pipeline_stall_ctrl_if.slave   bus
`ifdef STALL_CNT_EN
    ,
    output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

    state_t                state_q;
    state_t                state_d;
    ctrl_t                 ctrl;
    logic [MISS_CNT_W-1:0] miss_cnt_q;
    logic                  timeout_q;
    logic                  load_use;
    logic                  d_miss;
    logic                  i_miss;
    logic                  miss_sat;

    hazard_detect u_hazard_detect (
        .id_ex_memread (bus.id_ex_memread),
        .id_ex_rt      (bus.id_ex_rt),
        .if_id_rs      (bus.if_id_rs),
        .if_id_rt      (bus.if_id_rt),
        .load_use      (load_use)
    );

    // Once in DMISS the outstanding access is ours regardless of what mem_access shows now.
    assign d_miss   = !bus.data_hit && (bus.mem_access || (state_q == DMISS));
    assign i_miss   = !bus.instruction_hit;
    assign miss_sat = is_miss_state(state_q) && (miss_cnt_q == '1);

    // Mealy control decode by priority: D-miss, load-use, taken branch, I-miss.
    always_comb begin
        ctrl    = CTRL_RUN;
        state_d = RUN;
        if (!rst_n) begin
            ctrl    = CTRL_RESET;
            state_d = RUN;
        end else if (d_miss) begin
            ctrl.pc_we         = 1'b0;
            ctrl.if_id_we      = 1'b0;
            ctrl.id_ex_we      = 1'b0;
            ctrl.ex_mem_we     = 1'b0;
            ctrl.mem_wb_bubble = 1'b1;
            state_d            = DMISS;
        end else if (load_use) begin
            // One-cycle bubble; an I-miss still waiting keeps its state.
            ctrl.pc_we        = 1'b0;
            ctrl.if_id_we     = 1'b0;
            ctrl.id_ex_bubble = 1'b1;
            state_d           = ((state_q == IMISS) && i_miss) ? IMISS : RUN;
        end else if (bus.branch_taken) begin
            // Redirected fetch supersedes any pending I-miss.
            ctrl.if_id_flush = 1'b1;
            state_d          = RUN;
        end else if (i_miss) begin
            ctrl.pc_we       = 1'b0;
            ctrl.if_id_flush = 1'b1;
            state_d          = IMISS;
        end
    end

    // State, miss-wait counter and sticky timeout flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            miss_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (is_miss_state(state_d) && (state_d != state_q)) begin
                miss_cnt_q <= '0;
            end else if (is_miss_state(state_q) && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + MISS_CNT_W'(1);
            end
            if (miss_sat) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign bus.pc_we         = ctrl.pc_we;
    assign bus.if_id_we      = ctrl.if_id_we;
    assign bus.id_ex_we      = ctrl.id_ex_we;
    assign bus.ex_mem_we     = ctrl.ex_mem_we;
    assign bus.if_id_flush   = ctrl.if_id_flush;
    assign bus.id_ex_bubble  = ctrl.id_ex_bubble;
    assign bus.mem_wb_bubble = ctrl.mem_wb_bubble;
    // Flag shows in the very cycle the counter saturates, then holds until reset.
    assign bus.miss_timeout  = timeout_q || (rst_n && miss_sat);

`ifdef STALL_CNT_EN
    // Free-running count of cycles the PC was held, wrapping at full scale.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (!ctrl.pc_we) begin
            stall_cnt <= stall_cnt + STALL_CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb/tb_pipeline_stall_ctrl.sv - scoreboard bench for pipeline_stall_ctrl
module tb_pipeline_stall_ctrl;
    import pipeline_stall_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_stall_ctrl_if bus ();
`ifdef STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    pipeline_stall_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] ctrl;
        int         stall;
        string      tag;
    } exp_t;
    exp_t sb[$];

    // Reference model: 0=RUN 1=DMISS 2=IMISS
    int m_state   = 0;
    int m_run_len = 0;
    bit m_to      = 1'b0;
    int m_stall   = 0;

    // Drive one cycle, predict outputs, compare mid-cycle, advance the model at the edge.
    // Vector order: pc,if_id,id_ex,ex_mem we, if_id_flush, id_ex_bubble, mem_wb_bubble, miss_timeout
    task automatic cycle(input string tag, input bit rn, input bit ih, input bit dh, input bit ma,
                         input bit mr, input int rt, input int rs, input int rt2, input bit br);
        logic [7:0] e;
        int         nxt;
        bit         dm, lu, im, to_now;
        exp_t       got_e;
        rst_n               = rn;
        bus.instruction_hit = ih;
        bus.data_hit        = dh;
        bus.mem_access      = ma;
        bus.id_ex_memread   = mr;
        bus.id_ex_rt        = 5'(rt);
        bus.if_id_rs        = 5'(rs);
        bus.if_id_rt        = 5'(rt2);
        bus.branch_taken    = br;
        dm     = !dh && (ma || m_state == 1);
        lu     = mr && rt != 0 && (rt == rs || rt == rt2);
        im     = !ih;
        to_now = m_to || (m_state != 0 && m_run_len >= 256);
        nxt    = 0;
        if (!rn)      e = {7'b0000_111, m_to};
        else if (dm)  begin e = {7'b0000_001, to_now}; nxt = 1; end
        else if (lu)  begin e = {7'b0011_010, to_now}; nxt = (m_state == 2 && im) ? 2 : 0; end
        else if (br)  e = {7'b1111_100, to_now};
        else if (im)  begin e = {7'b0111_100, to_now}; nxt = 2; end
        else          e = {7'b1111_000, to_now};
        sb.push_back('{ctrl: e, stall: m_stall, tag: tag});
        @(negedge clk);
        got_e = sb.pop_front();
        check(got_e.tag, {24'd0, bus.pc_we, bus.if_id_we, bus.id_ex_we, bus.ex_mem_we,
                          bus.if_id_flush, bus.id_ex_bubble, bus.mem_wb_bubble, bus.miss_timeout},
              {24'd0, got_e.ctrl});
`ifdef STALL_CNT_EN
        check({got_e.tag, "_stall"}, {16'd0, stall_cnt}, got_e.stall);
`endif
        @(posedge clk);
        if (!rn) begin
            m_state = 0; m_run_len = 0; m_to = 1'b0; m_stall = 0;
        end else begin
            if (!e[7]) m_stall = (m_stall + 1) & 16'hFFFF;
            if (to_now) m_to = 1'b1;
            if (nxt != 0 && nxt != m_state) m_run_len = 1;
            else if (nxt != 0)              m_run_len++;
            m_state = nxt;
        end
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.instruction_hit = 1'b1; bus.data_hit = 1'b1; bus.mem_access = 1'b0;
        bus.id_ex_memread = 1'b0; bus.id_ex_rt = '0; bus.if_id_rs = '0; bus.if_id_rt = '0;
        bus.branch_taken = 1'b0;
        @(posedge clk); #1;

        // Reset dominates whatever the hazard inputs say.
        cycle("rst_a", 0, 0, 0, 1, 1, 3, 3, 0, 1);
        cycle("rst_b", 0, 1, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 10; i++) begin
            cycle("idle", 1, 1, 1, 0, 0, 0, 0, 0, 0);
            check("idle_state", 32'(dut.state_q), 32'(RUN));
        end

        for (int i = 0; i < 3; i++) cycle("dmiss", 1, 1, 0, 1, 0, 0, 0, 0, 0);
        cycle("dmiss_exit", 1, 1, 1, 1, 0, 0, 0, 0, 0);
`ifdef STALL_CNT_EN
        check("stall_cnt_3", {16'd0, stall_cnt}, 32'd3);
`endif
        check("dmiss_exit_state", 32'(dut.state_q), 32'(RUN));

        cycle("lu_rs", 1, 1, 1, 0, 1, 5, 5, 7, 0);
        cycle("lu_after", 1, 1, 1, 0, 0, 5, 5, 7, 0);
        cycle("lu_rt", 1, 1, 1, 0, 1, 9, 2, 9, 0);
        cycle("lu_r0", 1, 1, 1, 0, 1, 0, 0, 0, 0);
        cycle("lu_noread", 1, 1, 1, 0, 0, 5, 5, 5, 0);
        cycle("branch", 1, 1, 1, 0, 0, 0, 0, 0, 1);
        cycle("lu_branch", 1, 1, 1, 0, 1, 4, 4, 0, 1);
        cycle("branch_imiss", 1, 0, 1, 0, 0, 0, 0, 0, 1);

        cycle("imiss_a", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle("imiss_b", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        cycle("imiss_lu", 1, 0, 1, 0, 1, 6, 6, 0, 0);
        cycle("imiss_exit", 1, 1, 1, 0, 0, 0, 0, 0, 0);

        cycle("both_miss_a", 1, 0, 0, 1, 0, 0, 0, 0, 0);
        cycle("both_miss_b", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle("dhit_imiss", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        check("to_imiss_state", 32'(dut.state_q), 32'(IMISS));
        cycle("imiss_dmiss", 1, 0, 0, 1, 0, 0, 0, 0, 0);
        cycle("dmiss_hold", 1, 1, 0, 0, 0, 0, 0, 0, 0);
        cycle("dmiss_release", 1, 1, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 200; i++) begin
            cycle("rand", 1, ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0),
                  $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 3), ($urandom_range(0, 5) == 0));
        end
        cycle("settle", 1, 1, 1, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 260; i++) cycle("long_miss", 1, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle("post_timeout", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        check("timeout_sticky", 32'(bus.miss_timeout), 32'd1);

        for (int i = 0; i < 3; i++) cycle("pre_rst_miss", 1, 1, 0, 1, 0, 0, 0, 0, 0);
        cycle("rst_mid_miss", 0, 1, 0, 1, 0, 0, 0, 0, 0);
        check("rst_state", 32'(dut.state_q), 32'(RUN));
        cycle("post_rst", 1, 1, 1, 0, 0, 0, 0, 0, 0);
        check("post_rst_timeout", 32'(bus.miss_timeout), 32'd0);
        for (int i = 0; i < 4; i++) cycle("post_rst_dmiss", 1, 1, 0, 1, 0, 0, 0, 0, 0);
        cycle("post_rst_exit", 1, 1, 1, 0, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
